des_sbox_sequencer: RTL and testbench
=====================================

# des_sbox_sequencer

Time-multiplexed substitution controller for the DES round function. It accepts one 48-bit post-key-mix word (E(R) xor K) and steps its eight 6-bit groups through a shared S-box lookup datapath, N groups per cycle. It assembles the 32-bit substitution result and hands it to the P-permutation stage over a valid/ready handshake. It sits between the key-mix XOR and the permutation in the round pipeline.

## Interface
- SBOX_PER_CYCLE, 1, groups looked up per cycle; legal values 1, 2, 4, 8 (checked at elaboration).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  [1:48]  bits 1..6 feed S1, …, bits 43..48 feed S8.
- abort  input  1  synchronous cancel of the current word.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  [1:32]  S1 output in bits 1..4, …, S8 output in bits 29..32.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the shift register, clear the accumulator and group counter, and go to RUN.
- RUN: each cycle, the top 6·N bits of the shift register drive N lookup instances. Lookup instance j selects table (counter·N + j + 1).
  - Lookup rule:
    - Row = {b1,b6} of the group.
    - Column = b2..b5.
    - Output is a 4-bit value, MSB first.
  - On the edge:
    - Shift results into the accumulator from the LSB side, earlier groups toward bit 1.
    - Shift the input register left by 6·N.
    - counter += 1.
  - When counter reaches 8/N − 1, the edge moves to DONE.
- DONE:
  - out_valid=1; out_data is the accumulator, held stable.
  - On out_ready, go to IDLE.
  - Backpressure holds DONE indefinitely.
- abort:
  - In RUN or DONE: the next state is IDLE, and no output is produced.
  - abort has priority over the normal transition and over out_ready.
  - In IDLE, abort has priority over in_valid: the word is not accepted.
- Counter width is 3 bits. No wrap beyond 8/N − 1 is reachable.

## Timing
- Reset value of every register and output is 0: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_data=0, busy=0.
- Latency: out_valid rises 8/N cycles after the accept edge (8 for N=1, 1 for N=8).
- Throughput: one word per 8/N + 2 cycles when out_ready is tied high. The cycles are accept, RUN×(8/N), and DONE with handoff. No overlap: in_ready=0 throughout RUN and DONE.
- The lookup path is combinational within a cycle. Outputs are registered except in_ready and busy, which decode state.
- Reset mid-operation:
  - The asynchronous clear returns the block to IDLE immediately.
  - The partial result is discarded.
  - out_valid drops without waiting for a clock.
- in_data is sampled only on the accept edge. Later changes are ignored.

## Structure
- Shared package des_pkg holds:
  - the state encoding;
  - the S1–S8 tables as a constant array [1:8][0:3][0:15] of 4-bit values;
  - group width 6, output nibble width 4, group count 8.
- Sub-module des_sbox_lookup takes a 3-bit table index and a [1:6] input, and produces a [1:4] output.
  - It is purely combinational and indexes the package tables.
  - des_sbox_sequencer instantiates it SBOX_PER_CYCLE times through generate.

## Test plan
- Reset, then in_data=48'h0 with out_ready=1 -> out_data=32'hEFA72C4D. For N=1, out_valid rises 8 cycles after accept and lasts 1 cycle.
- in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB. Repeat for N=1, 2, 4, 8; check latency is 8/N each time.
- in_data=48'h6117BA866527 -> 32'h5C82B597. Hold out_ready=0 for 5 cycles: out_valid and out_data stay stable and in_ready stays 0. Release: the block returns to IDLE on the next edge.
- Pulse abort in RUN cycle 3 -> IDLE next edge, out_valid never asserts. The following word, 48'h0, returns 32'hEFA72C4D.
- Pulse rst_n low mid-RUN and in DONE -> out_valid, busy and out_data go to 0 asynchronously and in_ready=1. A subsequent word completes correctly.
- Back-to-back in_valid held high with out_ready=1 and words 0, all-ones, 6117BA866527 -> results in order. Accept spacing is 8/N + 2 cycles, and no word is lost or duplicated.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES substitution definitions: sequencer state encoding, S1-S8 tables
// and the group/nibble geometry used by the S-box sequencer and its lookups.
package des_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int GROUP_W   = 6;
   localparam int NIBBLE_W  = 4;
   localparam int GROUP_CNT = 8;

   // Each 64-bit literal is one table row, column 0 in the top nibble.
   localparam logic [1:8][0:3][0:15][3:0] SBOX_TABLE = {
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational single S-box lookup: i_table 0..7 selects S1..S8, row from the
// outer group bits, column from the inner four.
module des_sbox_lookup
   import des_pkg::*;
(
   input  logic [2:0] i_table,
   input  logic [1:6] i_group,
   output logic [1:4] o_nibble
);

   logic [1:0] w_row;
   logic [3:0] w_col;
   logic [3:0] w_sel;

   assign w_row    = {i_group[1], i_group[6]};
   assign w_col    = i_group[2:5];
   assign w_sel    = {1'b0, i_table} + 4'd1;
   assign o_nibble = SBOX_TABLE[w_sel][w_row][w_col];

endmodule

// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES substitution: steps eight 6-bit groups through
// SBOX_PER_CYCLE shared lookups and hands the 32-bit result downstream.
module des_sbox_sequencer
   import des_pkg::*;
#(
   parameter int SBOX_PER_CYCLE = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:48] in_data,
   input  logic        abort,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:32] out_data,
   output logic        busy,
   output state_t      dbg_state
);

   // Handshakes: a word transfers on a rising edge where valid and ready are
   // both high; valid never waits on ready, and out_data is held while
   // out_valid is high and out_ready is low.

   localparam int         STEPS    = GROUP_CNT / SBOX_PER_CYCLE;
   localparam int         SHIFT_W  = GROUP_W * SBOX_PER_CYCLE;
   localparam int         RES_W    = NIBBLE_W * SBOX_PER_CYCLE;
   localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

   if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
       SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_param
      $error("des_sbox_sequencer: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
   end

   state_t           r_state;
   state_t           w_next;
   logic [1:48]      r_shift;
   logic [1:32]      r_acc;
   logic [2:0]       r_cnt;
   logic             r_out_valid;
   logic [RES_W-1:0] w_res;
   logic             w_accept;
   logic             w_step;

   // Instance j handles the j-th group of this step; earlier groups land nearer bit 1.
   for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lookup
      logic [2:0] w_tbl;
      assign w_tbl = 3'(int'(r_cnt) * SBOX_PER_CYCLE + j);
      des_sbox_lookup u_lookup (
         .i_table  (w_tbl),
         .i_group  (r_shift[1 + GROUP_W*j +: GROUP_W]),
         .o_nibble (w_res[RES_W - 1 - NIBBLE_W*j -: NIBBLE_W])
      );
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_step   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!abort && in_valid) begin
               w_next   = ST_RUN;
               w_accept = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_next = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (r_cnt == LAST_CNT) w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort || out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_valid <= (w_next == ST_DONE);
         if (w_accept) begin
            r_shift <= in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
         end else if (w_step) begin
            r_shift <= r_shift << SHIFT_W;
            r_acc   <= (r_acc << RES_W) | 32'(w_res);
            r_cnt   <= r_cnt + 3'd1;
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_acc;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed-plus-random bench for des_sbox_sequencer at N = 1, 2, 4 and 8,
// checked against a table-driven substitution model.
module tb_des_sbox_sequencer;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid  [4];
   logic        abort_s   [4];
   logic        out_ready [4];
   logic        in_ready  [4];
   logic        out_valid [4];
   logic        busy      [4];
   logic [1:48] in_data   [4];
   logic [1:32] out_data  [4];
   state_t      dbg_state [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      des_sbox_sequencer #(.SBOX_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .abort     (abort_s[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g]),
         .dbg_state (dbg_state[g])
      );
   end

   // Standard DES S1..S8, four rows each, column 0 in the top nibble.
   logic [63:0] ref_tbl [0:31] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

   function automatic logic [31:0] ref_f(input logic [47:0] x);
      logic [31:0] r;
      int grp, row, col;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         grp = int'((x >> (42 - 6*k)) & 48'h3f);
         row = ((grp >> 5) & 1) * 2 + (grp & 1);
         col = (grp >> 1) & 15;
         r   = (r << 4) | 32'((ref_tbl[k*4 + row] >> (60 - 4*col)) & 64'hf);
      end
      return r;
   endfunction

   function automatic logic [47:0] rand48();
      return 48'({$urandom, $urandom});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int g, input logic [47:0] w);
      in_valid[g] = 1'b1;
      in_data[g]  = w;
      tick();
      in_valid[g] = 1'b0;
      in_data[g]  = rand48();
   endtask

   task automatic wait_out(input int g, output int lat);
      lat = 0;
      while (out_valid[g] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_word(input int g, input logic [47:0] w, input logic [31:0] exp, input string tag);
      int lat;
      out_ready[g] = 1'b1;
      send(g, w);
      wait_out(g, lat);
      chk($sformatf("N%0d_%s_latency", 1 << g, tag), lat, 8 >> g);
      chk($sformatf("N%0d_%s_data", 1 << g, tag), out_data[g], exp);
      chk($sformatf("N%0d_%s_busy_done", 1 << g, tag), {in_ready[g], busy[g]}, 2'b01);
      tick();
      chk($sformatf("N%0d_%s_valid_1cyc", 1 << g, tag), out_valid[g], 1'b0);
      chk($sformatf("N%0d_%s_idle_ready", 1 << g, tag), in_ready[g], 1'b1);
   endtask

   task automatic b2b(input int g);
      logic [47:0] words [5];
      logic [31:0] exp_q [$];
      int          idx, cyc, last_acc, got, extra;
      logic        rdy_prev;
      words    = '{48'h0, {48{1'b1}}, 48'h6117BA866527, rand48(), rand48()};
      idx      = 0;
      cyc      = 0;
      last_acc = -1;
      got      = 0;
      out_ready[g] = 1'b1;
      in_valid[g]  = 1'b1;
      in_data[g]   = words[0];
      rdy_prev     = in_ready[g];
      while ((idx < 5 || exp_q.size() > 0) && cyc < 200) begin
         tick();
         cyc++;
         if (rdy_prev && in_valid[g]) begin
            exp_q.push_back(ref_f(words[idx]));
            if (last_acc >= 0)
               chk($sformatf("N%0d_b2b_spacing", 1 << g), cyc - last_acc, (8 >> g) + 2);
            last_acc = cyc;
            idx++;
            if (idx < 5) in_data[g] = words[idx];
            else         in_valid[g] = 1'b0;
         end
         if (out_valid[g] === 1'b1) begin
            if (exp_q.size() == 0) chk($sformatf("N%0d_b2b_unexpected", 1 << g), out_valid[g], 1'b0);
            else                   chk($sformatf("N%0d_b2b_data", 1 << g), out_data[g], exp_q.pop_front());
            got++;
         end
         rdy_prev = in_ready[g];
      end
      in_valid[g] = 1'b0;
      extra = 0;
      repeat ((8 >> g) + 3) begin
         tick();
         if (out_valid[g] === 1'b1) extra++;
      end
      chk($sformatf("N%0d_b2b_count", 1 << g), got, 5);
      chk($sformatf("N%0d_b2b_extra", 1 << g), extra, 0);
   endtask

   task automatic pulse_reset_check(input int g, input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("N%0d_%s_valid", 1 << g, tag), out_valid[g], 1'b0);
      chk($sformatf("N%0d_%s_busy", 1 << g, tag), busy[g], 1'b0);
      chk($sformatf("N%0d_%s_data", 1 << g, tag), out_data[g], 32'h0);
      chk($sformatf("N%0d_%s_ready", 1 << g, tag), in_ready[g], 1'b1);
      #3 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int          s, c, lat, seen;
      logic [47:0] w;
      for (int g = 0; g < 4; g++) begin
         in_valid[g]  = 1'b0;
         abort_s[g]   = 1'b0;
         out_ready[g] = 1'b1;
         in_data[g]   = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("N%0d_rst_valid", 1 << g), out_valid[g], 1'b0);
         chk($sformatf("N%0d_rst_data", 1 << g), out_data[g], 32'h0);
         chk($sformatf("N%0d_rst_ready", 1 << g), in_ready[g], 1'b1);
         chk($sformatf("N%0d_rst_busy", 1 << g), busy[g], 1'b0);
         chk($sformatf("N%0d_rst_state", 1 << g), dbg_state[g], ST_IDLE);
      end

      for (int g = 0; g < 4; g++) begin
         s = 8 >> g;
         run_word(g, 48'h0, 32'hEFA72C4D, "zero");
         run_word(g, {48{1'b1}}, 32'hD9CE3DCB, "ones");
         repeat (3) begin
            w = rand48();
            run_word(g, w, ref_f(w), "rand");
         end

         // Backpressure holds the result.
         out_ready[g] = 1'b0;
         send(g, 48'h6117BA866527);
         wait_out(g, lat);
         chk($sformatf("N%0d_bp_latency", 1 << g), lat, s);
         chk($sformatf("N%0d_bp_data", 1 << g), out_data[g], 32'h5C82B597);
         repeat (5) begin
            tick();
            chk($sformatf("N%0d_bp_hold_valid", 1 << g), out_valid[g], 1'b1);
            chk($sformatf("N%0d_bp_hold_data", 1 << g), out_data[g], 32'h5C82B597);
            chk($sformatf("N%0d_bp_hold_ready", 1 << g), in_ready[g], 1'b0);
         end
         out_ready[g] = 1'b1;
         tick();
         chk($sformatf("N%0d_bp_release_valid", 1 << g), out_valid[g], 1'b0);
         chk($sformatf("N%0d_bp_release_ready", 1 << g), in_ready[g], 1'b1);

         // Abort in RUN (cycle 3, or the last RUN cycle when shorter).
         c = (s < 3) ? s : 3;
         send(g, rand48());
         repeat (c - 1) tick();
         abort_s[g] = 1'b1;
         tick();
         abort_s[g] = 1'b0;
         chk($sformatf("N%0d_abort_run_ready", 1 << g), in_ready[g], 1'b1);
         chk($sformatf("N%0d_abort_run_busy", 1 << g), busy[g], 1'b0);
         chk($sformatf("N%0d_abort_run_valid", 1 << g), out_valid[g], 1'b0);
         seen = 0;
         repeat (s + 2) begin
            tick();
            if (out_valid[g] === 1'b1) seen++;
         end
         chk($sformatf("N%0d_abort_run_no_out", 1 << g), seen, 0);
         run_word(g, 48'h0, 32'hEFA72C4D, "post_abort");

         // Abort in DONE beats out_ready.
         out_ready[g] = 1'b0;
         send(g, rand48());
         wait_out(g, lat);
         abort_s[g]   = 1'b1;
         out_ready[g] = 1'b1;
         tick();
         abort_s[g] = 1'b0;
         chk($sformatf("N%0d_abort_done_valid", 1 << g), out_valid[g], 1'b0);
         chk($sformatf("N%0d_abort_done_ready", 1 << g), in_ready[g], 1'b1);

         // Abort in IDLE blocks acceptance.
         in_valid[g] = 1'b1;
         abort_s[g]  = 1'b1;
         in_data[g]  = rand48();
         tick();
         in_valid[g] = 1'b0;
         abort_s[g]  = 1'b0;
         chk($sformatf("N%0d_abort_idle_ready", 1 << g), in_ready[g], 1'b1);
         chk($sformatf("N%0d_abort_idle_busy", 1 << g), busy[g], 1'b0);

         // Asynchronous reset mid-RUN, then in DONE.
         send(g, rand48());
         if (s > 1) tick();
         pulse_reset_check(g, "rst_run");
         w = rand48();
         run_word(g, w, ref_f(w), "after_rst_run");
         out_ready[g] = 1'b0;
         w = rand48();
         send(g, w);
         wait_out(g, lat);
         chk($sformatf("N%0d_rst_done_pre_data", 1 << g), out_data[g], ref_f(w));
         pulse_reset_check(g, "rst_done");
         out_ready[g] = 1'b1;
         w = rand48();
         run_word(g, w, ref_f(w), "after_rst_done");

         b2b(g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
